output_pacer: RTL and testbench

//  Chatter-free output driver for LEDs, relays and indicator segments.

---
 rtl/output_pacer.sv | 127 ++++++++++++
 tb/tb_output_pacer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_pacer.sv
// Paced single-bit output driver: every level is held for DWELL_CYCLES clocks,
// requests arriving during a hold are merged (last wins) and applied when the hold ends.
module output_pacer #(
  parameter int CNT_W        = 16,
  parameter int DWELL_CYCLES = 65535,
  parameter int PULSE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_on,
  input  logic req_off,
  input  logic req_toggle,
  input  logic req_pulse,
  output logic out_state,
  output logic changed_on,
  output logic changed_off,
  output logic busy,
  output logic pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    PULSE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             on_q;
  logic             off_q;
  logic             pend_q;
  logic             tgt_q;

  logic lvl_req;
  logic lvl_tgt;
  logic ref_lvl;
  logic pulse_req;
  logic pend_d;
  logic tgt_d;

  // Request decode: off > on > toggle > pulse; pend_d/tgt_d hold the merged request.
  always_comb begin
    ref_lvl   = pend_q ? tgt_q : out_q;
    lvl_req   = req_off | req_on | req_toggle;
    lvl_tgt   = req_off ? 1'b0 : (req_on ? 1'b1 : ~ref_lvl);
    pulse_req = req_pulse & ~lvl_req;
    pend_d    = pend_q | lvl_req;
    tgt_d     = lvl_req ? lvl_tgt : tgt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= 1'b0;
    end else begin
      on_q  <= 1'b0;
      off_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lvl_req && (lvl_tgt != out_q)) begin
            out_q   <= lvl_tgt;
            on_q    <= lvl_tgt;
            off_q   <= ~lvl_tgt;
            cnt_q   <= '0;
            state_q <= DWELL;
          end else if (pulse_req && !out_q) begin
            out_q   <= 1'b1;
            on_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= PULSE;
          end
        end
        DWELL: begin
          // The request sampled on the hold-end edge takes part in the decision.
          if (cnt_q == DwellLast) begin
            pend_q <= 1'b0;
            tgt_q  <= 1'b0;
            cnt_q  <= '0;
            if (pend_d && (tgt_d != out_q)) begin
              out_q <= tgt_d;
              on_q  <= tgt_d;
              off_q <= ~tgt_d;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
          end
        end
        PULSE: begin
          pend_q <= pend_d;
          tgt_q  <= tgt_d;
          if (cnt_q == PulseLast) begin
            out_q   <= 1'b0;
            off_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= DWELL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_state   = out_q;
  assign changed_on  = on_q;
  assign changed_off = off_q;
  assign busy        = (state_q != IDLE);
  assign pending     = pend_q;

endmodule

// File: tb/tb_output_pacer.sv
// Bench for output_pacer: directed scenarios then random requests, compared against
// a remaining-time reference model of the pacing rules.
module tb_output_pacer;

  localparam int DWELL = 4;
  localparam int PULSE = 3;

  logic clk;
  logic rst_n;
  logic req_on;
  logic req_off;
  logic req_toggle;
  logic req_pulse;
  logic out_state;
  logic changed_on;
  logic changed_off;
  logic busy;
  logic pending;

  int checks   = 0;
  int failures = 0;

  // Reference model state: level plus cycles remaining in the current hold or pulse.
  bit mLevel;
  bit mOn;
  bit mOff;
  bit mPending;
  bit mTarget;
  int mHoldLeft;
  int mPulseLeft;

  output_pacer #(
    .CNT_W       (16),
    .DWELL_CYCLES(DWELL),
    .PULSE_CYCLES(PULSE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_on     (req_on),
    .req_off    (req_off),
    .req_toggle (req_toggle),
    .req_pulse  (req_pulse),
    .out_state  (out_state),
    .changed_on (changed_on),
    .changed_off(changed_off),
    .busy       (busy),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mLevel     = 1'b0;
    mOn        = 1'b0;
    mOff       = 1'b0;
    mPending   = 1'b0;
    mTarget    = 1'b0;
    mHoldLeft  = 0;
    mPulseLeft = 0;
  endtask

  task automatic modelStep(input bit on, input bit off, input bit tog, input bit pul);
    bit lvlReq;
    bit lvlTgt;
    bit refLvl;
    mOn    = 1'b0;
    mOff   = 1'b0;
    refLvl = mPending ? mTarget : mLevel;
    lvlReq = on | off | tog;
    lvlTgt = off ? 1'b0 : (on ? 1'b1 : !refLvl);
    if (mPulseLeft > 0 || mHoldLeft > 0) begin
      if (lvlReq) begin
        mPending = 1'b1;
        mTarget  = lvlTgt;
      end
      if (mPulseLeft > 0) begin
        mPulseLeft = mPulseLeft - 1;
        if (mPulseLeft == 0) begin
          mLevel    = 1'b0;
          mOff      = 1'b1;
          mHoldLeft = DWELL;
        end
      end else begin
        mHoldLeft = mHoldLeft - 1;
        if (mHoldLeft == 0) begin
          if (mPending && mTarget != mLevel) begin
            mLevel    = mTarget;
            mOn       = mTarget;
            mOff      = !mTarget;
            mHoldLeft = DWELL;
          end
          mPending = 1'b0;
        end
      end
    end else if (lvlReq) begin
      if (lvlTgt != mLevel) begin
        mLevel    = lvlTgt;
        mOn       = lvlTgt;
        mOff      = !lvlTgt;
        mHoldLeft = DWELL;
      end
    end else if (pul && !mLevel) begin
      mLevel     = 1'b1;
      mOn        = 1'b1;
      mPulseLeft = PULSE;
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, ".out_state"}, out_state, mLevel);
    checkBit({tag, ".changed_on"}, changed_on, mOn);
    checkBit({tag, ".changed_off"}, changed_off, mOff);
    checkBit({tag, ".busy"}, busy, (mHoldLeft > 0 || mPulseLeft > 0));
    checkBit({tag, ".pending"}, pending, mPending);
  endtask

  task automatic applyStimulus(input bit on, input bit off, input bit tog, input bit pul,
                               input string tag);
    req_on     = on;
    req_off    = off;
    req_toggle = tog;
    req_pulse  = pul;
    @(posedge clk);
    modelStep(on, off, tog, pul);
    #1;
    req_on     = 1'b0;
    req_off    = 1'b0;
    req_toggle = 1'b0;
    req_pulse  = 1'b0;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without a clock.
  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    #20;
    rst_n = 1'b1;
  endtask

  initial begin
    int highCount;
    bit ron, roff, rtog, rpul;
    rst_n      = 1'b0;
    req_on     = 1'b0;
    req_off    = 1'b0;
    req_toggle = 1'b0;
    req_pulse  = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t1_on");
    idleCycles(5, "t1_hold");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t2_prep_off");
    idleCycles(5, "t2_prep_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t2_on");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t2_off_pending");
    idleCycles(8, "t2_hold");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t3_on");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t3_off");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t3_on_again");
    idleCycles(6, "t3_hold");

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "t4_both");
    idleCycles(5, "t4_hold");

    highCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5_pulse");
    if (out_state === 1'b1) highCount++;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t5_pulse_run");
      if (out_state === 1'b1) highCount++;
    end
    checks++;
    assert (highCount == PULSE)
    else begin
      failures++;
      $error("[TB] FAIL t5_pulse_width observed=%0d expected=%0d", highCount, PULSE);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t5_on");
    idleCycles(5, "t5_on_hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5_pulse_ignored");
    idleCycles(2, "t5_after_ignore");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t6_off");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t6_on_pending");
    asyncReset("t6_async_reset");
    idleCycles(6, "t6_after_release");

    for (int i = 0; i < 600; i++) begin
      ron  = ($urandom_range(0, 7) == 0);
      roff = ($urandom_range(0, 7) == 0);
      rtog = ($urandom_range(0, 5) == 0);
      rpul = ($urandom_range(0, 5) == 0);
      applyStimulus(ron, roff, rtog, rpul, "random");
      if ($urandom_range(0, 199) == 0) asyncReset("random_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
